pp_cond_stream_filter: RTL and testbench

- Hardware reader for the conditional-directive token stream produced by the preprocessor front end.
- Consumes tokenised `define/`undef/`ifdef/`ifndef/`elsif/`else/`endif/TEXT records.
- Keeps a defined-macro bitmap and a nesting stack, and forwards only TEXT tokens from taken branches to the downstream parser over valid/ready.
- Flags structural directive errors.

---
 rtl/pp_cond_stream_filter.sv | 181 ++++++++++++++++++
 tb/tb_pp_cond_stream_filter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_cond_stream_filter.sv
// Conditional-directive filter: tracks defined macros and nested `ifdef regions, forwards TEXT from taken branches.
// Latency: one cycle from an accepted TEXT token to out_valid; directives update state in the accept cycle.
// Backpressure: one-entry output register; in_ready = !out_valid | out_ready, held output is stable while stalled.
module pp_cond_stream_filter #(
    parameter int ID_W   = 6,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_kind,
    input  logic [ID_W-1:0]            in_id,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       active,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [2:0] K_TEXT   = 3'd0;
    localparam logic [2:0] K_DEFINE = 3'd1;
    localparam logic [2:0] K_UNDEF  = 3'd2;
    localparam logic [2:0] K_IFDEF  = 3'd3;
    localparam logic [2:0] K_IFNDEF = 3'd4;
    localparam logic [2:0] K_ELSIF  = 3'd5;
    localparam logic [2:0] K_ELSE   = 3'd6;
    localparam logic [2:0] K_ENDIF  = 3'd7;

    // Branch state per nesting level; zero doubles as the cleared value.
    localparam logic [1:0] S_TAKE = 2'd0;
    localparam logic [1:0] S_SEEK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] E_UNMATCHED = 2'd1;
    localparam logic [1:0] E_ELSE_ORD  = 2'd2;
    localparam logic [1:0] E_OVERFLOW  = 2'd3;

    logic [2**ID_W-1:0] bitmap;
    logic [1:0]         st_state [DEPTH];
    logic [DEPTH-1:0]   st_else;

    logic               accept;
    logic [AW-1:0]      top_idx;
    logic [AW-1:0]      push_idx;
    logic [1:0]         top_state;
    logic               top_else;
    logic               at_zero;
    logic               cond_bit;
    logic               load_text;
    logic               err_hit;
    logic [1:0]         err_new;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign at_zero   = (depth == '0);
    assign top_idx   = AW'(depth - DW'(1));
    assign push_idx  = AW'(depth);
    assign top_state = at_zero ? S_TAKE : st_state[top_idx];
    assign top_else  = at_zero ? 1'b0 : st_else[top_idx];
    assign active    = at_zero || (top_state == S_TAKE);
    assign cond_bit  = bitmap[in_id];
    assign load_text = accept && (in_kind == K_TEXT) && active;

    // Classify structural errors for the token being offered this cycle.
    always_comb begin
        err_hit = 1'b0;
        err_new = 2'd0;
        case (in_kind)
            K_ELSIF, K_ELSE: begin
                if (at_zero) begin
                    err_hit = 1'b1;
                    err_new = E_UNMATCHED;
                end else if (top_else) begin
                    err_hit = 1'b1;
                    err_new = E_ELSE_ORD;
                end
            end
            K_ENDIF: begin
                if (at_zero) begin
                    err_hit = 1'b1;
                    err_new = E_UNMATCHED;
                end
            end
            K_IFDEF, K_IFNDEF: begin
                if (depth == DEPTH_MAX) begin
                    err_hit = 1'b1;
                    err_new = E_OVERFLOW;
                end
            end
            default: begin
                err_hit = 1'b0;
                err_new = 2'd0;
            end
        endcase
    end

    // One-entry output register: load on an emitted TEXT, otherwise drain on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_text) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Macro bitmap, nesting stack and sticky error state, updated once per accepted directive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap   <= '0;
            st_else  <= '0;
            depth    <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                st_state[i] <= S_TAKE;
            end
        end else if (accept) begin
            if (err_hit) begin
                err <= 1'b1;
                if (!err) begin
                    err_code <= err_new;
                end
            end else begin
                case (in_kind)
                    K_DEFINE: begin
                        if (active) bitmap[in_id] <= 1'b1;
                    end
                    K_UNDEF: begin
                        if (active) bitmap[in_id] <= 1'b0;
                    end
                    K_IFDEF, K_IFNDEF: begin
                        // An inactive parent forces the child straight to DONE.
                        if (!active) begin
                            st_state[push_idx] <= S_DONE;
                        end else if (cond_bit ^ (in_kind == K_IFNDEF)) begin
                            st_state[push_idx] <= S_TAKE;
                        end else begin
                            st_state[push_idx] <= S_SEEK;
                        end
                        st_else[push_idx] <= 1'b0;
                        depth             <= depth + DW'(1);
                    end
                    K_ELSIF: begin
                        if (top_state == S_SEEK && cond_bit) begin
                            st_state[top_idx] <= S_TAKE;
                        end else if (top_state == S_TAKE) begin
                            st_state[top_idx] <= S_DONE;
                        end
                    end
                    K_ELSE: begin
                        if (top_state == S_SEEK) begin
                            st_state[top_idx] <= S_TAKE;
                        end else if (top_state == S_TAKE) begin
                            st_state[top_idx] <= S_DONE;
                        end
                        st_else[top_idx] <= 1'b1;
                    end
                    K_ENDIF: begin
                        depth <= depth - DW'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pp_cond_stream_filter.sv
// Directed bench for pp_cond_stream_filter: walks the directive scenarios and output backpressure.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Emitted TEXT is collected by a falling-edge monitor and compared against hand-computed lists.
module tb_pp_cond_stream_filter;

    localparam int ID_W   = 6;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;

    localparam logic [2:0] K_TEXT   = 3'd0;
    localparam logic [2:0] K_DEFINE = 3'd1;
    localparam logic [2:0] K_UNDEF  = 3'd2;
    localparam logic [2:0] K_IFDEF  = 3'd3;
    localparam logic [2:0] K_IFNDEF = 3'd4;
    localparam logic [2:0] K_ELSIF  = 3'd5;
    localparam logic [2:0] K_ELSE   = 3'd6;
    localparam logic [2:0] K_ENDIF  = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [ID_W-1:0]   in_id;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              active;
    logic [3:0]        depth;
    logic              err;
    logic [1:0]        err_code;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] got_q[$];

    pp_cond_stream_filter #(.ID_W(ID_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_id     (in_id),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .active    (active),
        .depth     (depth),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Record every output transfer that will complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one token and hold it until accepted; returns at rising edge + 1.
    task automatic send(input logic [2:0] kind, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data);
        int n;
        in_valid = 1'b1;
        in_kind  = kind;
        in_id    = id;
        in_data  = data;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL send_timeout observed=in_ready_low expected=accept_within_100");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_kind   = K_TEXT;
        in_id     = '0;
        in_data   = '0;
        out_ready = 1'b1;
        idle(2);

        // Reset values
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_depth", depth, 0);
        check("rst_active", active, 1);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        idle(1);

        // Scenario 1: ELSIF picks the defined macro
        send(K_DEFINE, 6'd5, 16'h0);
        send(K_IFDEF, 6'd9, 16'h0);
        check("s1_depth_in", depth, 1);
        check("s1_active_seek", active, 0);
        send(K_TEXT, 6'd0, 16'hAAAA);
        send(K_ELSIF, 6'd5, 16'h0);
        check("s1_active_elsif", active, 1);
        send(K_TEXT, 6'd0, 16'h1111);
        send(K_ELSE, 6'd0, 16'h0);
        check("s1_active_else", active, 0);
        send(K_TEXT, 6'd0, 16'hBBBB);
        send(K_ENDIF, 6'd0, 16'h0);
        idle(3);
        check("s1_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("s1_data0", got_q[0], 16'h1111);
        check("s1_depth_end", depth, 0);
        check("s1_err", err, 0);
        got_q.delete();

        // Scenario 2: ELSE branch with a DEFINE visible to the next IFDEF
        send(K_IFDEF, 6'd1, 16'h0);
        send(K_ELSIF, 6'd2, 16'h0);
        send(K_TEXT, 6'd0, 16'h2222);
        send(K_ELSE, 6'd0, 16'h0);
        send(K_DEFINE, 6'd7, 16'h0);
        send(K_TEXT, 6'd0, 16'h3333);
        send(K_ENDIF, 6'd0, 16'h0);
        send(K_IFDEF, 6'd7, 16'h0);
        check("s2_active_id7", active, 1);
        send(K_TEXT, 6'd0, 16'h4444);
        send(K_ENDIF, 6'd0, 16'h0);
        idle(3);
        check("s2_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("s2_data0", got_q[0], 16'h3333);
            check("s2_data1", got_q[1], 16'h4444);
        end
        got_q.delete();

        // Scenario 3: nest under an untaken branch stays silent
        send(K_IFDEF, 6'd9, 16'h0);
        check("s3_depth1", depth, 1);
        send(K_IFNDEF, 6'd9, 16'h0);
        check("s3_depth2", depth, 2);
        check("s3_active_nest", active, 0);
        send(K_TEXT, 6'd0, 16'h5555);
        send(K_ELSE, 6'd0, 16'h0);
        check("s3_active_else", active, 0);
        send(K_TEXT, 6'd0, 16'h6666);
        send(K_ENDIF, 6'd0, 16'h0);
        check("s3_active_outer", active, 0);
        send(K_ENDIF, 6'd0, 16'h0);
        check("s3_depth_end", depth, 0);
        check("s3_active_end", active, 1);
        idle(3);
        check("s3_count", got_q.size(), 0);
        got_q.delete();

        // Scenario 4: unmatched ENDIF then double ELSE; first code kept
        send(K_ENDIF, 6'd0, 16'h0);
        check("s4_err", err, 1);
        check("s4_code_first", err_code, 1);
        check("s4_depth_zero", depth, 0);
        send(K_IFDEF, 6'd3, 16'h0);
        send(K_ELSE, 6'd0, 16'h0);
        check("s4_active_else", active, 1);
        send(K_ELSE, 6'd0, 16'h0);
        check("s4_active_dropped", active, 1);
        check("s4_code_kept", err_code, 1);
        check("s4_depth_kept", depth, 1);
        send(K_ENDIF, 6'd0, 16'h0);
        check("s4_depth_end", depth, 0);
        do_reset();
        check("s4_err_cleared", err, 0);
        check("s4_code_cleared", err_code, 0);

        // Scenario 5: overflow at DEPTH, depth saturates
        for (int i = 0; i < 8; i++) send(K_IFDEF, 6'd0, 16'h0);
        check("s5_depth_full", depth, 8);
        check("s5_err_none", err, 0);
        send(K_IFDEF, 6'd0, 16'h0);
        check("s5_depth_sat", depth, 8);
        check("s5_err", err, 1);
        check("s5_code", err_code, 3);
        for (int i = 0; i < 8; i++) send(K_ENDIF, 6'd0, 16'h0);
        check("s5_depth_end", depth, 0);
        check("s5_code_kept", err_code, 3);
        got_q.delete();

        // Scenario 6: TEXT burst under a 3-cycle downstream stall
        out_ready = 1'b0;
        send(K_TEXT, 6'd0, 16'h0001);
        in_valid = 1'b1;
        in_kind  = K_TEXT;
        in_data  = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s6_stall_in_ready", in_ready, 0);
            check("s6_stall_valid", out_valid, 1);
            check("s6_stall_data", out_data, 16'h0001);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(K_TEXT, 6'd0, 16'h0002);
        send(K_TEXT, 6'd0, 16'h0003);
        send(K_TEXT, 6'd0, 16'h0004);
        idle(3);
        check("s6_count", got_q.size(), 4);
        if (got_q.size() >= 4) begin
            check("s6_data0", got_q[0], 16'h0001);
            check("s6_data1", got_q[1], 16'h0002);
            check("s6_data2", got_q[2], 16'h0003);
            check("s6_data3", got_q[3], 16'h0004);
        end
        got_q.delete();

        // Scenario 7: reset mid-stream drops pending output, stack and bitmap
        send(K_DEFINE, 6'd2, 16'h0);
        send(K_IFDEF, 6'd2, 16'h0);
        out_ready = 1'b0;
        send(K_TEXT, 6'd0, 16'h0005);
        check("s7_pending", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("s7_rst_valid", out_valid, 0);
        check("s7_rst_depth", depth, 0);
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        send(K_IFDEF, 6'd2, 16'h0);
        check("s7_depth_from0", depth, 1);
        check("s7_bitmap_cleared", active, 0);
        send(K_ENDIF, 6'd0, 16'h0);
        send(K_TEXT, 6'd0, 16'h0007);
        idle(3);
        check("s7_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("s7_data0", got_q[0], 16'h0007);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
